adder_tree_acc_ctrl: RTL and testbench

//  Sequences the 25-input pipelined adder tree (fixed 5-cycle latency, no valid/enable) for one conv job.

---
 rtl/adder_tree_acc_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_adder_tree_acc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc_ctrl.sv
// Job sequencer for a 25-input pipelined adder tree. It issues product windows, tags them through a
// latency-matched pipe, accumulates channel passes, and queues each result behind credit-based flow control.
module adder_tree_acc_ctrl #(
    parameter int SUM_W      = 22,
    parameter int ACC_W      = 32,
    parameter int TREE_LAT   = 5,
    parameter int CH_W       = 8,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CH_W-1:0]  num_ch,
    input  logic [OUT_W-1:0] num_out,
    output logic             busy,
    output logic             done,
    input  logic             win_valid,
    output logic             win_ready,
    input  logic [SUM_W-1:0] tree_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CRD_W = PTR_W + 1;
    localparam int ENT_W = ACC_W + 1;
    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [ACC_W-1:0] sext(input logic [SUM_W-1:0] v);
        return {{(ACC_W-SUM_W){v[SUM_W-1]}}, v};
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic               run_s;
    logic [CH_W-1:0]    ch_last_r;
    logic [OUT_W-1:0]   out_last_idx_r;
    logic [CH_W-1:0]    pass_r;
    logic [OUT_W-1:0]   out_idx_r;
    logic [CRD_W-1:0]   credits_r;
    logic               issue_s;
    logic               pass_last_s;
    logic               job_last_s;
    logic               take_s;
    logic               pop_s;
    logic               push_s;
    logic               pipe_busy_s;
    logic               fifo_empty_s;
    // Index k holds the tag of the window issued k edges ago; index TREE_LAT lines up with tree_sum.
    logic [TREE_LAT:0]  vld_pipe_r;
    logic [TREE_LAT:0]  first_pipe_r;
    logic [TREE_LAT:0]  last_pipe_r;
    logic [TREE_LAT:0]  jlast_pipe_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   sum_ext_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [ACC_W-1:0]   push_data_s;
    logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
    logic [ENT_W-1:0]   head_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CRD_W-1:0]   count_r;

    assign issue_s      = win_valid & win_ready;
    assign pass_last_s  = (pass_r == ch_last_r);
    assign job_last_s   = pass_last_s & (out_idx_r == out_last_idx_r);
    assign take_s       = issue_s & (pass_r == {CH_W{1'b0}});
    assign pop_s        = out_valid & out_ready;
    assign push_s       = vld_pipe_r[TREE_LAT] & last_pipe_r[TREE_LAT];
    assign pipe_busy_s  = |vld_pipe_r;
    assign fifo_empty_s = (count_r == {CRD_W{1'b0}});
    assign sum_ext_s    = sext(tree_sum);
    assign acc_sum_s    = acc_r + sum_ext_s;
    assign push_data_s  = first_pipe_r[TREE_LAT] ? sum_ext_s : acc_sum_s;
    assign head_s       = mem_r[rd_ptr_r];

    // A credit is only needed on pass 0, where a new FIFO slot gets reserved.
    assign win_ready = run_s & ((pass_r != {CH_W{1'b0}}) | (credits_r != {CRD_W{1'b0}}));
    assign out_valid = ~fifo_empty_s;
    assign out_data  = out_valid ? head_s[ACC_W-1:0] : {ACC_W{1'b0}};
    assign out_last  = out_valid & head_s[ACC_W];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (num_out == {OUT_W{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && job_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy_s && fifo_empty_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        run_s = 1'b0;
        case (state_r)
            ST_IDLE:  busy = 1'b0;
            ST_RUN:   begin busy = 1'b1; run_s = 1'b1; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  busy = 1'b0;
        endcase
    end

    // Job configuration latch plus pass/output counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_last_r      <= {CH_W{1'b0}};
            out_last_idx_r <= {OUT_W{1'b0}};
            pass_r         <= {CH_W{1'b0}};
            out_idx_r      <= {OUT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            ch_last_r      <= (num_ch == {CH_W{1'b0}}) ? {CH_W{1'b0}} : (num_ch - CH_W'(1'b1));
            out_last_idx_r <= num_out - OUT_W'(1'b1);
            pass_r         <= {CH_W{1'b0}};
            out_idx_r      <= {OUT_W{1'b0}};
        end else if (issue_s) begin
            if (pass_last_s) begin
                pass_r    <= {CH_W{1'b0}};
                out_idx_r <= out_idx_r + OUT_W'(1'b1);
            end else begin
                pass_r    <= pass_r + CH_W'(1'b1);
            end
        end
    end

    // FIFO slot credits: taken on pass-0 issue, returned on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_r <= CRD_FULL;
        end else begin
            case ({take_s, pop_s})
                2'b10:   credits_r <= credits_r - CRD_W'(1'b1);
                2'b01:   credits_r <= credits_r + CRD_W'(1'b1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Tag pipe matched to the tree latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_r   <= {(TREE_LAT+1){1'b0}};
            first_pipe_r <= {(TREE_LAT+1){1'b0}};
            last_pipe_r  <= {(TREE_LAT+1){1'b0}};
            jlast_pipe_r <= {(TREE_LAT+1){1'b0}};
        end else begin
            vld_pipe_r   <= {vld_pipe_r[TREE_LAT-1:0], issue_s};
            first_pipe_r <= {first_pipe_r[TREE_LAT-1:0], (pass_r == {CH_W{1'b0}})};
            last_pipe_r  <= {last_pipe_r[TREE_LAT-1:0], pass_last_s};
            jlast_pipe_r <= {jlast_pipe_r[TREE_LAT-1:0], job_last_s};
        end
    end

    // Channel accumulator, restarted by the first pass of each output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (vld_pipe_r[TREE_LAT]) begin
            acc_r <= push_data_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CRD_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CRD_W'(1'b1);
                2'b01:   count_r <= count_r - CRD_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are masked by out_valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {jlast_pipe_r[TREE_LAT], push_data_s};
        end
    end
endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Directed bench for adder_tree_acc_ctrl; a delay-line model plays the adder tree, answering
// each issued window with its scripted sum exactly TREE_LAT clocks after the issue edge.
module tb_adder_tree_acc_ctrl;
    localparam int SUM_W    = 22;
    localparam int ACC_W    = 32;
    localparam int TREE_LAT = 5;
    localparam int CH_W     = 8;
    localparam int OUT_W    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [CH_W-1:0]  num_ch = 8'd1;
    logic [OUT_W-1:0] num_out = 16'd1;
    logic             busy, done, win_valid, win_ready, out_valid, out_ready, out_last;
    logic [SUM_W-1:0] tree_sum;
    logic [ACC_W-1:0] out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_issue = 0;
    int done_cnt = 0;
    int base;
    int dc;
    logic issue_pend = 1'b0;
    logic early;
    logic [SUM_W-1:0] win_q[$];
    int               sched_due[$];
    logic [SUM_W-1:0] sched_val[$];
    logic [ACC_W-1:0] got_data[$];
    logic             got_last[$];

    adder_tree_acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_ch(num_ch), .num_out(num_out),
        .busy(busy), .done(done), .win_valid(win_valid), .win_ready(win_ready),
        .tree_sum(tree_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Handshake monitor, sampled away from the active edge.
    always @(negedge clk) begin
        issue_pend = win_valid & win_ready;
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (done) done_cnt++;
    end

    // Adder-tree model: sum for an issue at edge t is presented right after edge t+TREE_LAT.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            sched_due.delete();
            sched_val.delete();
        end else if (issue_pend) begin
            n_issue++;
            sched_due.push_back(cyc + TREE_LAT);
            if (win_q.size() > 0) sched_val.push_back(win_q.pop_front());
            else sched_val.push_back({SUM_W{1'b0}});
        end
        #1;
        if (sched_due.size() > 0 && sched_due[0] == cyc) begin
            tree_sum = sched_val.pop_front();
            void'(sched_due.pop_front());
        end else begin
            tree_sum = SUM_W'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_win(input int v);
        win_q.push_back(SUM_W'(v));
    endtask

    task automatic start_job(input int ch, input int nout);
        num_ch  = CH_W'(ch);
        num_out = OUT_W'(nout);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic clear_got();
        got_data.delete();
        got_last.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        win_valid = 1'b0;
        out_ready = 1'b0;
        tree_sum  = {SUM_W{1'b0}};
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_win_ready", 64'(win_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // single pass, single output: latency and done-after-pop
        push_win(100);
        start_job(1, 1);
        win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        early = 1'b0;
        repeat (6) begin
            @(negedge clk);
            early = early | out_valid;
        end
        @(negedge clk);
        chk("t1_early", 64'(early), 64'd0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'd100);
        chk("t1_last", 64'(out_last), 64'd1);
        chk("t1_no_done", 64'(done_cnt), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("t1_done", 20);
        chk("t1_npop", 64'(got_data.size()), 64'd1);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_issues", 64'(n_issue), 64'd1);

        // three passes per output, two outputs
        clear_got();
        base = n_issue;
        push_win(10); push_win(-3); push_win(5);
        push_win(1);  push_win(1);  push_win(1);
        win_valid = 1'b1;
        start_job(3, 2);
        wait_done("t2_done", 60);
        win_valid = 1'b0;
        chk("t2_npop", 64'(got_data.size()), 64'd2);
        chk("t2_d0", 64'(got_data[0]), 64'd12);
        chk("t2_l0", 64'(got_last[0]), 64'd0);
        chk("t2_d1", 64'(got_data[1]), 64'd3);
        chk("t2_l1", 64'(got_last[1]), 64'd1);
        chk("t2_issues", 64'(n_issue - base), 64'd6);

        // backpressure: credits cap issue at FIFO depth
        clear_got();
        base = n_issue;
        dc = done_cnt;
        for (int i = 1; i <= 12; i++) push_win(i);
        out_ready = 1'b0;
        win_valid = 1'b1;
        start_job(1, 12);
        repeat (30) tick();
        chk("t3_capped", 64'(n_issue - base), 64'd8);
        chk("t3_stall", 64'(win_ready), 64'd0);
        chk("t3_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_done("t3_done", 200);
        win_valid = 1'b0;
        chk("t3_npop", 64'(got_data.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            chk("t3_data", 64'(got_data[i]), 64'(i + 1));
            chk("t3_last", 64'(got_last[i]), (i == 11) ? 64'd1 : 64'd0);
        end
        chk("t3_issues", 64'(n_issue - base), 64'd12);
        chk("t3_done_once", 64'(done_cnt - dc), 64'd1);

        // sign extension of an all-ones tree sum
        clear_got();
        push_win(-1); push_win(-1);
        win_valid = 1'b1;
        start_job(2, 1);
        wait_done("t4_done", 40);
        win_valid = 1'b0;
        chk("t4_data", 64'(got_data[0]), 64'h0000_0000_FFFF_FFFE);
        chk("t4_last", 64'(got_last[0]), 64'd1);

        // win_valid toggling every other cycle
        clear_got();
        base = n_issue;
        dc = done_cnt;
        push_win(1);  push_win(2); push_win(3);   push_win(4);
        push_win(-5); push_win(7); push_win(100); push_win(-2);
        start_job(4, 2);
        for (int i = 0; i < 200 && done_cnt == dc; i++) begin
            win_valid = ((i % 2) == 1);
            tick();
        end
        win_valid = 1'b0;
        chk("t5_done", 64'(done_cnt - dc), 64'd1);
        chk("t5_npop", 64'(got_data.size()), 64'd2);
        chk("t5_d0", 64'(got_data[0]), 64'd10);
        chk("t5_d1", 64'(got_data[1]), 64'd100);
        chk("t5_l1", 64'(got_last[1]), 64'd1);
        chk("t5_issues", 64'(n_issue - base), 64'd8);

        // asynchronous reset mid-job, then a clean job
        for (int i = 0; i < 8; i++) push_win(5);
        out_ready = 1'b0;
        win_valid = 1'b1;
        start_job(2, 4);
        repeat (12) tick();
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        chk("t6_pre_busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_win_ready", 64'(win_ready), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_out_last", 64'(out_last), 64'd0);
        win_valid = 1'b0;
        win_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_got();
        push_win(7); push_win(9);
        out_ready = 1'b1;
        win_valid = 1'b1;
        start_job(1, 2);
        wait_done("t6_done", 40);
        win_valid = 1'b0;
        chk("t6_npop", 64'(got_data.size()), 64'd2);
        chk("t6_d0", 64'(got_data[0]), 64'd7);
        chk("t6_l0", 64'(got_last[0]), 64'd0);
        chk("t6_d1", 64'(got_data[1]), 64'd9);

        // num_ch=0 acts as 1; start while busy is ignored
        clear_got();
        base = n_issue;
        dc = done_cnt;
        push_win(42);
        out_ready = 1'b0;
        win_valid = 1'b1;
        start_job(0, 1);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("t7_valid", 64'(out_valid), 64'd1);
        chk("t7_data", 64'(out_data), 64'd42);
        chk("t7_last", 64'(out_last), 64'd1);
        out_ready = 1'b1;
        wait_done("t7_done", 40);
        repeat (3) tick();
        chk("t7_idle", 64'(busy), 64'd0);
        chk("t7_issues", 64'(n_issue - base), 64'd1);
        chk("t7_done_once", 64'(done_cnt - dc), 64'd1);
        win_valid = 1'b0;

        // num_out=0 finishes on the next cycle without issuing
        base = n_issue;
        win_valid = 1'b1;
        start_job(1, 0);
        @(negedge clk);
        #1;
        chk("t8_done", 64'(done), 64'd1);
        chk("t8_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        chk("t8_done_off", 64'(done), 64'd0);
        chk("t8_idle", 64'(busy), 64'd0);
        chk("t8_issues", 64'(n_issue - base), 64'd0);
        win_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
